// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - light codes, fault codes and guard state for the lamp guard
package traffic_pkg;

  localparam logic [2:0] RED  = 3'b100;
  localparam logic [2:0] YEL  = 3'b010;
  localparam logic [2:0] GRN  = 3'b001;
  localparam logic [2:0] DARK = 3'b000;

  localparam logic [2:0] FC_NONE       = 3'd0;
  localparam logic [2:0] FC_ENCODING   = 3'd1;
  localparam logic [2:0] FC_CONFLICT   = 3'd2;
  localparam logic [2:0] FC_TRANSITION = 3'd3;
  localparam logic [2:0] FC_YEL_SHORT  = 3'd4;
  localparam logic [2:0] FC_YEL_LONG   = 3'd5;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_NORMAL,
    ST_FAULT
  } guard_state_e;

  function automatic logic code_legal(input logic [2:0] code);
    return (code == RED) || (code == YEL) || (code == GRN);
  endfunction

endpackage

// File: rtl/traffic_dir_checker.sv
// rtl/traffic_dir_checker.sv - per-direction history, yellow timing and encoding/transition checks
module traffic_dir_checker
  import traffic_pkg::*;
#(
  parameter int unsigned YELLOW_MIN = 3,
  parameter int unsigned YELLOW_MAX = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] traffic,
  output logic       bad_enc,
  output logic       bad_trans,
  output logic       yel_short,
  output logic       yel_long,
  output logic       is_red
);

  logic [2:0] prev;
  logic [7:0] ycnt;
  logic [7:0] ycnt_nxt;

  // ycnt counts consecutive yellow cycles up to and including the previous sample
  always_comb begin
    ycnt_nxt = 8'd0;
    if (traffic == YEL) begin
      if (prev == YEL) begin
        ycnt_nxt = (ycnt == 8'hFF) ? ycnt : ycnt + 8'd1;
      end else begin
        ycnt_nxt = 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev <= RED;
      ycnt <= 8'd0;
    end else begin
      prev <= traffic;
      ycnt <= ycnt_nxt;
    end
  end

  assign is_red    = (traffic == RED);
  assign bad_enc   = !code_legal(traffic);
  assign bad_trans = ((prev == GRN) && (traffic == RED)) ||
                     ((prev == RED) && (traffic == YEL)) ||
                     ((prev == YEL) && (traffic == GRN)) ||
                     (!code_legal(prev) && (traffic != prev));
  assign yel_short = (prev == YEL) && (traffic != YEL) && (32'(ycnt) < YELLOW_MIN);
  assign yel_long  = (traffic == YEL) && (32'(ycnt_nxt) > YELLOW_MAX);

endmodule

// File: rtl/traffic_lamp_guard.sv
// rtl/traffic_lamp_guard.sv - safety guard between the light controller and the physical lamps
module traffic_lamp_guard
  import traffic_pkg::*;
#(
  parameter int unsigned YELLOW_MIN = 3,
  parameter int unsigned YELLOW_MAX = 5,
  parameter int unsigned FLASH_HALF = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] traffic_A,
  input  logic [2:0] traffic_B,
  input  logic       fault_clr,
  output logic [2:0] lamp_A,
  output logic [2:0] lamp_B,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [7:0] fault_cnt
);

  localparam int unsigned FLASH_W = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
  localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(FLASH_HALF - 1);

  logic enc_a, trans_a, short_a, long_a, red_a;
  logic enc_b, trans_b, short_b, long_b, red_b;

  traffic_dir_checker #(.YELLOW_MIN(YELLOW_MIN), .YELLOW_MAX(YELLOW_MAX)) u_chk_a (
    .clk       (clk),
    .rst       (rst),
    .traffic   (traffic_A),
    .bad_enc   (enc_a),
    .bad_trans (trans_a),
    .yel_short (short_a),
    .yel_long  (long_a),
    .is_red    (red_a)
  );

  traffic_dir_checker #(.YELLOW_MIN(YELLOW_MIN), .YELLOW_MAX(YELLOW_MAX)) u_chk_b (
    .clk       (clk),
    .rst       (rst),
    .traffic   (traffic_B),
    .bad_enc   (enc_b),
    .bad_trans (trans_b),
    .yel_short (short_b),
    .yel_long  (long_b),
    .is_red    (red_b)
  );

  guard_state_e       state, state_nxt;
  logic [FLASH_W-1:0] flash_cnt, flash_cnt_nxt;
  logic               flash_on, flash_on_nxt;
  logic [2:0]         lamp_a_nxt, lamp_b_nxt;
  logic               fault_nxt;
  logic [2:0]         code_nxt;
  logic [7:0]         cnt_nxt;
  logic [2:0]         cause;
  logic               both_red;

  assign both_red = red_a && red_b;

  // lowest-numbered cause wins when several fire together
  always_comb begin
    cause = FC_NONE;
    if (enc_a || enc_b) begin
      cause = FC_ENCODING;
    end else if (!red_a && !red_b) begin
      cause = FC_CONFLICT;
    end else if (trans_a || trans_b) begin
      cause = FC_TRANSITION;
    end else if (short_a || short_b) begin
      cause = FC_YEL_SHORT;
    end else if (long_a || long_b) begin
      cause = FC_YEL_LONG;
    end
  end

  always_comb begin
    state_nxt     = state;
    flash_cnt_nxt = flash_cnt;
    flash_on_nxt  = flash_on;
    lamp_a_nxt    = lamp_A;
    lamp_b_nxt    = lamp_B;
    fault_nxt     = fault;
    code_nxt      = fault_code;
    cnt_nxt       = fault_cnt;
    case (state)
      ST_INIT: begin
        lamp_a_nxt = RED;
        lamp_b_nxt = RED;
        if (both_red) begin
          state_nxt = ST_NORMAL;
        end
      end
      ST_NORMAL: begin
        if (cause != FC_NONE) begin
          // the offending code is replaced on the same edge, so it never reaches a lamp
          state_nxt     = ST_FAULT;
          fault_nxt     = 1'b1;
          code_nxt      = cause;
          cnt_nxt       = (fault_cnt == 8'hFF) ? fault_cnt : fault_cnt + 8'd1;
          lamp_a_nxt    = RED;
          lamp_b_nxt    = RED;
          flash_cnt_nxt = '0;
          flash_on_nxt  = 1'b1;
        end else begin
          lamp_a_nxt = traffic_A;
          lamp_b_nxt = traffic_B;
        end
      end
      ST_FAULT: begin
        if (fault_clr && both_red) begin
          state_nxt  = ST_NORMAL;
          fault_nxt  = 1'b0;
          code_nxt   = FC_NONE;
          lamp_a_nxt = RED;
          lamp_b_nxt = RED;
        end else begin
          if (flash_cnt == FLASH_LAST) begin
            flash_cnt_nxt = '0;
            flash_on_nxt  = !flash_on;
          end else begin
            flash_cnt_nxt = flash_cnt + 1'b1;
          end
          lamp_a_nxt = flash_on_nxt ? RED : DARK;
          lamp_b_nxt = flash_on_nxt ? RED : DARK;
        end
      end
      default: begin
        state_nxt = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_INIT;
      flash_cnt  <= '0;
      flash_on   <= 1'b1;
      lamp_A     <= RED;
      lamp_B     <= RED;
      fault      <= 1'b0;
      fault_code <= FC_NONE;
      fault_cnt  <= 8'd0;
    end else begin
      state      <= state_nxt;
      flash_cnt  <= flash_cnt_nxt;
      flash_on   <= flash_on_nxt;
      lamp_A     <= lamp_a_nxt;
      lamp_B     <= lamp_b_nxt;
      fault      <= fault_nxt;
      fault_code <= code_nxt;
      fault_cnt  <= cnt_nxt;
    end
  end

endmodule

// File: doc/traffic_lamp_guard.md
Name: traffic_lamp_guard

Overview:
- Sits directly downstream of the traffic light controller.
- Consumes the controller's per-direction light codes (traffic_A, traffic_B) and drives the physical lamp outputs.
- Checks every cycle for illegal encodings, conflicting right-of-way, illegal phase transitions and out-of-bounds yellow time.
- On any violation it latches a fault code and overrides both lamps with flashing red until an operator clear is accepted.

Parameters:
- YELLOW_MIN, 3: minimum consecutive yellow cycles before leaving yellow.
- YELLOW_MAX, 5: maximum consecutive yellow cycles allowed.
- FLASH_HALF, 2: cycles per half-period of fault flashing; must be ≥1.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- traffic_A  in  3  controller code, direction A: bit2=red, bit1=yellow, bit0=green.
- traffic_B  in  3  controller code, direction B, same encoding.
- fault_clr  in  1  operator clear request, level-sampled.
- lamp_A  out  3  lamp drive, direction A, same encoding.
- lamp_B  out  3  lamp drive, direction B.
- fault  out  1  high while in FAULT.
- fault_code  out  3  first fault cause since last clear; 0 = none.
- fault_cnt  out  8  number of FAULT entries, saturates at 255.

Behaviour:
- Reset (rst=0, asynchronous, any time including mid-flash):
  - state=INIT; lamp_A=lamp_B=3'b100; fault=0; fault_code=0; fault_cnt=0.
  - Previous-value registers = 100/100; yellow counters = 0.
- Legal per-direction codes: 100 R, 010 Y, 001 G. All other values are illegal.
- Previous-value registers: prev_X <= traffic_X every cycle in every state.
- Yellow counter ycnt_X, per direction, saturating:
  - traffic_X==Y: next = (prev_X==Y) ? ycnt_X+1 : 1.
  - Otherwise: next = 0.
- Checks are evaluated on the current inputs only in NORMAL. Codes, with lowest code winning when several occur in the same cycle:
  - 1 illegal encoding on either direction.
  - 2 conflict: neither direction is R.
  - 3 illegal transition: G→R, R→Y, Y→G, or any change away from an illegal previous value.
  - 4 yellow too short: prev_X==Y, traffic_X≠Y, ycnt_X<YELLOW_MIN.
  - 5 yellow too long: traffic_X==Y and next ycnt_X>YELLOW_MAX.
- State INIT:
  - Lamps held at 100/100; no checks.
  - Moves to NORMAL on the first edge where both inputs are 100.
- State NORMAL:
  - No fault: lamp_X <= traffic_X, one cycle latency.
  - Any fault detected: on the same edge, state←FAULT, fault←1, fault_code←cause, fault_cnt+1 (saturating), lamps←100/100. An illegal value never reaches the lamps.
- State FAULT:
  - Lamps alternate 100/100 for FLASH_HALF cycles, then 000/000 for FLASH_HALF cycles, starting with the on phase.
  - Further faults are ignored; fault_code keeps the first cause.
  - Exit on an edge where fault_clr=1 AND both inputs are 100: state←NORMAL, fault←0, fault_code←0, lamps←100/100.
  - fault_clr with either input not red has no effect.
- fault_cnt is cleared only by reset.

Decomposition:
- Package traffic_pkg holds:
  - Light code constants: RED=100, YEL=010, GRN=001, DARK=000.
  - Fault code constants: 1–5.
  - Guard state enum: INIT, NORMAL, FAULT.
- Sub-module traffic_dir_checker, instantiated once per direction:
  - Contains the prev register, yellow counter, encoding check, transition check and yellow-bound checks.
  - Outputs per-cause flags and is_red.
- The top level holds the conflict check, priority encoder, FSM, flash counter and lamp/fault registers.

Test Plan:
- Reset, hold both inputs 100 for 2 cycles, then run A: G for 10 cycles, Y for 3, R; then B the same → state reaches NORMAL; lamps equal the inputs delayed one cycle; fault stays 0 throughout.
- In NORMAL drive traffic_A=011 → on that edge fault=1, fault_code=1, fault_cnt=1; lamps read 100/100 for 2 cycles, 000/000 for 2 cycles, repeating; 011 never appears on lamp_A.
- Drive A=001 and B=001 together → fault_code=2; in a separate run, A G→R directly → fault_code=3.
- A yellow for 1 cycle then R → fault_code=4; A held yellow → fault on the 6th yellow cycle with fault_code=5.
- In FAULT, pulse fault_clr with A=001 → stays in FAULT. Then both inputs 100 plus fault_clr → NORMAL next edge with fault=0, fault_code=0, fault_cnt unchanged.
- Assert rst low mid-flash while lamps are 000 → lamps go to 100/100 immediately (asynchronously) and fault_cnt=0.
